bin_to_bcd_seq: RTL and testbench
=================================

# bin_to_bcd_seq

Sequential binary-to-BCD converter (shift-add-3 / double dabble) that consumes the unsigned product from the calculator's shift-add multiplier and produces packed BCD digits for the display driver. It runs one conversion per `start` pulse with a start/busy/done handshake matching the multiplier control. It sits directly downstream of the multiplier datapath, with `start` typically driven by the multiplier's `done`.

## Interface
- `WIDTH`, 16: binary input width; the multiplier product is 8x8.
- `DIGITS`, 5: number of BCD output digits. Configuration constraint: 10^DIGITS > 2^WIDTH - 1.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high; sampled on the `clk` rising edge.
- `start` input 1: conversion request; sampled only in IDLE.
- `bin_in` input WIDTH: unsigned binary operand; sampled on the same edge that samples `start`.
- `bcd_out` output 4*DIGITS: packed BCD result, least-significant digit in bits [3:0]; registered.
- `busy` output 1: high while a conversion is in progress.
- `done` output 1: one-cycle pulse marking a valid `bcd_out`.

## Operation
- FSM states: IDLE, LOAD, ADJUST, SHIFT, DONE_ST.
- IDLE: if `start` is high, capture `bin_in` into the binary shift register and go to LOAD. Otherwise stay in IDLE.
- LOAD: clear the BCD working register, load the bit counter with WIDTH, go to ADJUST.
- ADJUST: every 4-bit digit of the working register that is >= 5 gets +3, in parallel across all digits. Go to SHIFT.
- SHIFT: shift the concatenation {BCD working, binary} left by 1, with the binary MSB entering BCD bit 0. Decrement the counter.
  - If the counter was 1 before the decrement, go to DONE_ST and load `bcd_out` from the post-shift working value on the same edge.
  - Otherwise go back to ADJUST.
- DONE_ST: `done`=1, go to IDLE.
- Outputs:
  - `busy`=1 in LOAD, ADJUST and SHIFT; 0 in IDLE and DONE_ST.
  - `done`=1 only in DONE_ST.
- `bcd_out` holds its value between conversions; it changes only on entry to DONE_ST or on reset.
- `start` is ignored in LOAD, ADJUST, SHIFT and DONE_ST; there is no queuing.
- The bit counter is clog2(WIDTH+1) bits wide. The working register never overflows when the DIGITS constraint holds.
- Illegal state encodings go to IDLE on the next edge.

## Timing
- Reset values:
  - state = IDLE.
  - `bcd_out` = 0, `busy` = 0, `done` = 0.
  - Working registers and counter = 0.
- Reset mid-conversion: the edge with `reset`=1 forces IDLE and clears `bcd_out`. `done` never pulses for the aborted conversion.
- Reset has priority over `start` on the same edge.
- Latency: with `start` sampled high at edge E:
  - LOAD for one cycle.
  - Then WIDTH ADJUST/SHIFT pairs.
  - `done` and the new `bcd_out` are valid in the cycle after edge E + 2*WIDTH + 1, i.e. 2*WIDTH+2 edges after E. For WIDTH=16 that is the cycle after edge E+33.
- `busy` rises in the cycle after E and falls in the cycle where `done` rises.
- Back-to-back throughput: `start` high in the cycle after the DONE_ST cycle (FSM back in IDLE) begins a new conversion. Minimum spacing between `start` acceptances is 2*WIDTH+3 cycles.
- `bin_in` need not be held after the accepting edge.

## Test plan
- Reset then `bin_in`=0, `start` pulse:
  - `bcd_out`=0x00000.
  - `done` high exactly in the cycle after edge E+33.
  - `busy` high for the 33 cycles before it.
- `bin_in`=65535 (max):
  - `bcd_out`=0x65535.
  - `bin_in`=9 gives 0x00009; `bin_in`=10 gives 0x00010 (digit-carry boundary).
- `bin_in`=1234, then `bin_in` changed to 999 the cycle after `start`:
  - `bcd_out`=0x01234, confirming the operand was captured at `start`.
- Busy-start and back-to-back:
  - Start 4321; pulse `start` with 5555 mid-conversion; result is 0x04321 and only one `done` pulse occurs.
  - Then `start` with 5555 immediately in IDLE: second `done` gives 0x05555.
- Reset mid-conversion:
  - `bin_in`=40000, assert `reset` for one cycle at edge E+10.
  - `bcd_out`=0, `busy`=0, no `done`.
  - A subsequent conversion of 77 yields 0x00077.
- `bcd_out` hold:
  - After a conversion of 250, idle for 100 cycles with `bin_in` toggling and `start` low.
  - `bcd_out` stays 0x00250 and `done` stays 0.

Source files
------------

// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and data bundle between the multiplier control and the
// binary-to-BCD converter. master drives the request, slave returns the result.
interface bin_to_bcd_seq_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  start;
    logic [WIDTH-1:0]      bin_in;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  busy;
    logic                  done;

    modport master (
        output start,
        output bin_in,
        input  bcd_out,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  bin_in,
        output bcd_out,
        output busy,
        output done
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3 / double dabble).
// One conversion per accepted start: LOAD, then WIDTH ADJUST/SHIFT pairs,
// then a single DONE_ST cycle with bcd_out updated on entry.
module bin_to_bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic              clk,
    input  logic              reset,
    bin_to_bcd_seq_if.slave   bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        ADJUST  = 3'd2,
        SHIFT   = 3'd3,
        DONE_ST = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   bin_sr;
    logic [BCD_W-1:0]   bcd_work;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_shift;
    logic [CNT_W-1:0]   cnt;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and status outputs
    always_comb begin
        state_nxt = IDLE;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = bus.start ? LOAD : IDLE;
            end
            LOAD: begin
                bus.busy  = 1'b1;
                state_nxt = ADJUST;
            end
            ADJUST: begin
                bus.busy  = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                bus.busy  = 1'b1;
                state_nxt = (cnt == CNT_W'(1)) ? DONE_ST : ADJUST;
            end
            DONE_ST: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Add 3 to every digit >= 5, all digits in parallel
    always_comb begin
        bcd_adj = bcd_work;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (bcd_work[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd_work[4*d +: 4] + 4'd3;
            end
        end
    end

    // Post-shift working value; also the value captured into bcd_out on the last shift
    always_comb begin
        bcd_shift = {bcd_work[BCD_W-2:0], bin_sr[WIDTH-1]};
    end

    // Datapath: operand capture, digit adjust, shift, counter and result register
    always_ff @(posedge clk) begin
        if (reset) begin
            bin_sr      <= '0;
            bcd_work    <= '0;
            cnt         <= '0;
            bus.bcd_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bin_sr <= bus.bin_in;
                    end
                end
                LOAD: begin
                    bcd_work <= '0;
                    cnt      <= CNT_W'(WIDTH);
                end
                ADJUST: begin
                    bcd_work <= bcd_adj;
                end
                SHIFT: begin
                    bcd_work <= bcd_shift;
                    bin_sr   <= {bin_sr[WIDTH-2:0], 1'b0};
                    cnt      <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        bus.bcd_out <= bcd_shift;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed boundary cases plus random
// operands, compared against a decimal-digit reference computed with / and %.
module tb_bin_to_bcd_seq;
    localparam int WIDTH   = 16;
    localparam int DIGITS  = 5;
    localparam int LATENCY = 2 * WIDTH + 1;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    bin_to_bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal digits by repeated division
    function automatic logic [4*DIGITS-1:0] to_bcd(input int unsigned v);
        logic [4*DIGITS-1:0] r;
        int unsigned         x;
        r = '0;
        x = v;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start with v, optionally re-pulse start with mid_v at cycle mid_k,
    // and return in the cycle where done is first seen (or after a bound).
    task automatic convert(input string tag, input logic [WIDTH-1:0] v,
                           input logic [WIDTH-1:0] after_v,
                           input int mid_k, input logic [WIDTH-1:0] mid_v);
        int busy_cnt;
        int done_at;
        bus.bin_in = v;
        bus.start  = 1'b1;
        step();
        bus.start  = 1'b0;
        bus.bin_in = after_v;
        busy_cnt   = 0;
        done_at    = -1;
        for (int k = 0; k <= LATENCY + 8; k++) begin
            if (bus.done) begin
                done_at = k;
                break;
            end
            if (bus.busy) busy_cnt++;
            if (k == mid_k) begin
                bus.start  = 1'b1;
                bus.bin_in = mid_v;
            end else begin
                bus.start  = 1'b0;
            end
            step();
        end
        bus.start = 1'b0;
        check({tag, "_latency"}, 32'(done_at), 32'(LATENCY));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(LATENCY));
        check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        check({tag, "_bcd"}, 32'(bus.bcd_out), 32'(to_bcd(v)));
    endtask

    initial begin
        logic [WIDTH-1:0] r;
        int               done_seen;
        errors     = 0;
        checks     = 0;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.bin_in = '0;
        step();
        step();
        reset = 1'b0;
        check("reset_bcd",  32'(bus.bcd_out), 32'd0);
        check("reset_busy", 32'(bus.busy),    32'd0);
        check("reset_done", 32'(bus.done),    32'd0);
        step();

        convert("zero", 16'd0, 16'd0, -1, 16'd0);
        step();
        convert("max", 16'd65535, 16'd0, -1, 16'd0);
        check("max_value", 32'(bus.bcd_out), 32'h65535);
        step();
        convert("nine", 16'd9, 16'd0, -1, 16'd0);
        check("nine_value", 32'(bus.bcd_out), 32'h00009);
        step();
        convert("ten", 16'd10, 16'd0, -1, 16'd0);
        check("ten_value", 32'(bus.bcd_out), 32'h00010);
        step();
        convert("capture", 16'd1234, 16'd999, -1, 16'd0);
        check("capture_value", 32'(bus.bcd_out), 32'h01234);
        step();

        // Start during busy is dropped; a start right after DONE_ST is accepted
        convert("busy_start", 16'd4321, 16'd0, 10, 16'd5555);
        check("busy_start_value", 32'(bus.bcd_out), 32'h04321);
        step();
        convert("back2back", 16'd5555, 16'd0, -1, 16'd0);
        check("back2back_value", 32'(bus.bcd_out), 32'h05555);
        step();

        // Reset sampled at E+10 aborts the conversion of 40000
        bus.bin_in = 16'd40000;
        bus.start  = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 9; k++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_bcd",  32'(bus.bcd_out), 32'd0);
        check("abort_busy", 32'(bus.busy),    32'd0);
        done_seen = 0;
        for (int k = 0; k < LATENCY + 10; k++) begin
            if (bus.done) done_seen++;
            step();
        end
        check("abort_no_done", 32'(done_seen), 32'd0);
        convert("after_abort", 16'd77, 16'd0, -1, 16'd0);
        check("after_abort_value", 32'(bus.bcd_out), 32'h00077);
        step();

        // Result holds while idle with bin_in moving
        convert("hold", 16'd250, 16'd0, -1, 16'd0);
        step();
        done_seen = 0;
        for (int k = 0; k < 100; k++) begin
            bus.bin_in = 16'($urandom);
            step();
            if (bus.done) done_seen++;
            if (k % 25 == 24) check("hold_bcd", 32'(bus.bcd_out), 32'h00250);
        end
        check("hold_no_done", 32'(done_seen), 32'd0);

        // Random operands, back to back
        for (int i = 0; i < 20; i++) begin
            r = 16'($urandom);
            convert("random", r, 16'($urandom), -1, 16'd0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
